alu_div_unit: RTL and testbench

- Iterative multi-cycle divider/remainder unit on the execute stage.
- Consumes the same operand pair that the operand-select muxes feed to the ALU (a = rs1 path, b = rs2 path).
- Returns the RV64M DIV/DIVU/REM/REMU result to the writeback side with a start/done handshake.
- The pipeline stalls on busy while the unit iterates.

---
 rtl/alu_div_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_unit.sv
// alu_div_unit: iterative RV64M DIV/DIVU/REM/REMU unit for the execute stage.
// Restoring division, one quotient bit per clock. Divide-by-zero and signed
// overflow bypass the iteration and complete in a single cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, accepted only while busy=0
//   flush  - synchronous abort; wins over start
//   op     - 00=DIV, 01=DIVU, 10=REM, 11=REMU
//   a, b   - dividend (rs1 path), divisor (rs2 path)
//   busy   - operation in flight (BUSY or DONE state)
//   done   - one-cycle pulse, result valid in that cycle
//   result - quotient or remainder, held until the next done
module alu_div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q;      // partial remainder, always < divisor
  logic [XLEN-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] dvsr_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            is_rem_q;

  logic            is_signed_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic [XLEN-1:0] a_abs_c;
  logic [XLEN-1:0] b_abs_c;
  logic            div_zero_c;
  logic            ovf_c;
  logic [XLEN-1:0] special_res_c;
  logic [XLEN:0]   rem_sh_c;
  logic [XLEN:0]   diff_c;
  logic            qbit_c;
  logic [XLEN-1:0] rem_nxt_c;
  logic [XLEN-1:0] quo_nxt_c;
  logic [XLEN-1:0] quo_fix_c;
  logic [XLEN-1:0] rem_fix_c;
  logic [XLEN-1:0] final_res_c;

  // Operand decode, magnitudes and single-cycle special cases.
  always_comb begin
    is_signed_c   = ~op[0];
    a_neg_c       = is_signed_c & a[XLEN-1];
    b_neg_c       = is_signed_c & b[XLEN-1];
    a_abs_c       = a_neg_c ? (~a + XLEN'(1)) : a;
    b_abs_c       = b_neg_c ? (~b + XLEN'(1)) : b;
    div_zero_c    = (b == '0);
    ovf_c         = is_signed_c && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special_res_c = '0;
    if (div_zero_c) begin
      special_res_c = op[1] ? a : '1;
    end else if (ovf_c) begin
      special_res_c = op[1] ? '0 : a;
    end
  end

  // One restoring step on an XLEN+1 bit shifted remainder, then sign fixup.
  always_comb begin
    rem_sh_c    = {1'b0, rem_q} << 1;
    rem_sh_c[0] = quo_q[XLEN-1];
    diff_c      = rem_sh_c - {1'b0, dvsr_q};
    qbit_c      = ~diff_c[XLEN];
    rem_nxt_c   = qbit_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
    quo_nxt_c   = {quo_q[XLEN-2:0], qbit_c};
    quo_fix_c   = neg_quo_q ? (~quo_nxt_c + XLEN'(1)) : quo_nxt_c;
    rem_fix_c   = neg_rem_q ? (~rem_nxt_c + XLEN'(1)) : rem_nxt_c;
    final_res_c = is_rem_q ? rem_fix_c : quo_fix_c;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      // Abort leaves result untouched so the last value stays readable.
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (div_zero_c || ovf_c) begin
              result <= special_res_c;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_abs_c;
              dvsr_q    <= b_abs_c;
              neg_quo_q <= a_neg_c ^ b_neg_c;
              neg_rem_q <= a_neg_c;
              is_rem_q  <= op[1];
              cnt       <= CW'(XLEN - 1);
              state     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_q <= rem_nxt_c;
          quo_q <= quo_nxt_c;
          if (cnt == '0) begin
            result <= final_res_c;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit: issued ops push expected result and
// latency into a queue; a monitor pops and compares on every done pulse.
module tb_alu_div_unit;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    int unsigned     acc;
    int unsigned     lat;
    string           name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [XLEN-1:0] MINV = 64'h8000_0000_0000_0000;

  alu_div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned lat;
    if (!rst && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got result=%h, required no done", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res) begin
          bad++;
          $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
        end
        total++;
        lat = cyc - e.acc + 1;
        if (lat != e.lat) begin
          bad++;
          $display("FAIL %s latency: got %0d, required %0d", e.name, lat, e.lat);
        end
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy_at_done: got %b, required 1", e.name, busy);
        end
      end
    end
  end

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s wait_idle: got busy=%b, required 0 within 300 cycles", name, busy);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s drain: got pending=%0d, required 0 within 300 cycles", name, sb.size());
    end
  endtask

  // Drive one start pulse; operands are scrambled afterwards.
  task automatic drive(input logic [1:0] o, input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
  endtask

  task automatic issue(input string name, input logic [1:0] o,
                       input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] exp, input int unsigned lat);
    exp_t e;
    wait_idle(name);
    e.res  = exp;
    e.acc  = cyc + 1;
    e.lat  = lat;
    e.name = name;
    sb.push_back(e);
    drive(o, x, y);
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_busy",   {63'd0, busy}, '0);
    check("reset_done",   {63'd0, done}, '0);
    check("reset_result", result, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue("divu_100_7",   OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    issue("remu_100_7",   OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    issue("div_m7_2",     OP_DIV,  -64'd7, 64'd2, -64'd3, 65);
    issue("rem_m7_2",     OP_REM,  -64'd7, 64'd2, -64'd1, 65);
    issue("rem_7_m2",     OP_REM,  64'd7, -64'd2, 64'd1, 65);
    issue("div_m100_m7",  OP_DIV,  -64'd100, -64'd7, 64'd14, 65);
    issue("divu_5_0",     OP_DIVU, 64'd5, 64'd0, ALL1, 1);
    issue("rem_5_0",      OP_REM,  64'd5, 64'd0, 64'd5, 1);
    issue("div_ovf",      OP_DIV,  MINV, ALL1, MINV, 1);
    issue("rem_ovf",      OP_REM,  MINV, ALL1, 64'd0, 1);
    issue("remu_big_16",  OP_REMU, ALL1, 64'h10, 64'hF, 65);
    issue("divu_big_1",   OP_DIVU, ALL1, 64'd1, ALL1, 65);

    // Flush mid-operation; a start pulse while busy must be ignored.
    wait_idle("flush_seq");
    drive(OP_DIVU, 64'd100, 64'd7);
    repeat (8) @(negedge clk);
    drive(OP_DIVU, 64'd50, 64'd5);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = OP_DIVU;
    a     = 64'd8;
    b     = 64'd0;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_busy",        {63'd0, busy}, '0);
    check("flush_done",        {63'd0, done}, '0);
    check("flush_result_held", result, ALL1);
    repeat (80) @(negedge clk);
    check("flush_stays_idle",  {63'd0, busy}, '0);
    issue("divu_9_3",     OP_DIVU, 64'd9, 64'd3, 64'd3, 65);

    // Asynchronous reset in the middle of an operation.
    wait_idle("rst_seq");
    drive(OP_DIVU, 64'd100, 64'd7);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",   {63'd0, busy}, '0);
    check("midrst_done",   {63'd0, done}, '0);
    check("midrst_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    issue("div_after_rst", OP_DIV, 64'd1000, -64'd10, -64'd100, 65);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
